// File: rtl/keccak_padder.sv
// keccak_padder: SHA-3 message padder and rate-block packer.
// Takes 32-bit message words (earliest byte in bits [31:24]), applies the
// SHA-3 padding (domain byte 0x06, closing bit 0x80) and shifts them into a
// 576-bit (18-word) rate block. It presents each full block with out_ready
// and holds it until the permutation acknowledges it with f_ack.
module keccak_padder (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  in,
   input  logic         in_ready,
   input  logic         is_last,
   input  logic [1:0]   byte_num,
   output logic         buffer_full,
   output logic [575:0] out,
   output logic         out_ready,
   input  logic         f_ack
);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_PAD  = 2'd1,
      ST_FULL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'd17;

   state_t         state_q, state_d;
   logic [4:0]     cnt_q, cnt_d;
   logic           last_seen_q, last_seen_d;
   logic [575:0]   out_q, out_d;
   logic           out_ready_q, out_ready_d;
   logic           buffer_full_q, buffer_full_d;

   // Build the final message word: keep the valid leading bytes, then the
   // 0x06 domain byte, then zeros. In the last slot of the block, the
   // closing 0x80 is merged into the low byte as well.
   function automatic logic [31:0] pad_last(input logic [31:0] word,
                                            input logic [1:0]  nbytes,
                                            input logic        at_end);
      logic [31:0] w;
      case (nbytes)
         2'd0:    w = 32'h0600_0000;
         2'd1:    w = {word[31:24], 24'h06_0000};
         2'd2:    w = {word[31:16], 16'h0600};
         2'd3:    w = {word[31:8], 8'h06};
         default: w = 32'h0600_0000;
      endcase
      return w | {24'h00_0000, at_end, 7'h00};
   endfunction

   // Next-state logic: word packing, padding and the ack handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_seen_d = last_seen_q;
      out_d       = out_q;
      case (state_q)
         ST_FILL: begin
            // buffer_full is low in FILL, so in_ready alone means accept.
            if (in_ready) begin
               cnt_d = (cnt_q == LAST_IDX) ? 5'd0 : cnt_q + 5'd1;
               if (is_last) begin
                  out_d       = {out_q[543:0], pad_last(in, byte_num, cnt_q == LAST_IDX)};
                  last_seen_d = 1'b1;
                  state_d     = (cnt_q == LAST_IDX) ? ST_FULL : ST_PAD;
               end else begin
                  out_d   = {out_q[543:0], in};
                  state_d = (cnt_q == LAST_IDX) ? ST_FULL : ST_FILL;
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_PAD: begin
            // Zero fill, with the closing bit in the final slot of the block.
            if (cnt_q == LAST_IDX) begin
               out_d   = {out_q[543:0], 32'h0000_0080};
               cnt_d   = 5'd0;
               state_d = ST_FULL;
            end else begin
               out_d   = {out_q[543:0], 32'h0000_0000};
               cnt_d   = cnt_q + 5'd1;
               state_d = ST_PAD;
            end
         end
         ST_FULL: begin
            if (f_ack) begin
               out_d   = '0;
               cnt_d   = 5'd0;
               state_d = last_seen_q ? ST_DONE : ST_FILL;
            end else begin
               state_d = ST_FULL;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_FILL;
            cnt_d   = 5'd0;
            out_d   = '0;
         end
      endcase
      // Handshake outputs are registered from the next state so that no
      // input reaches buffer_full or out_ready combinationally.
      out_ready_d   = (state_d == ST_FULL);
      buffer_full_d = (state_d != ST_FILL);
   end

   // State and datapath registers; reset overrides every other event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_FILL;
         cnt_q         <= 5'd0;
         last_seen_q   <= 1'b0;
         out_q         <= '0;
         out_ready_q   <= 1'b0;
         buffer_full_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_seen_q   <= last_seen_d;
         out_q         <= out_d;
         out_ready_q   <= out_ready_d;
         buffer_full_q <= buffer_full_d;
      end
   end

   assign out         = out_q;
   assign out_ready   = out_ready_q;
   assign buffer_full = buffer_full_q;

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder.
module tb_keccak_padder;

   logic         clk;
   logic         reset;
   logic [31:0]  in;
   logic         in_ready;
   logic         is_last;
   logic [1:0]   byte_num;
   logic         buffer_full;
   logic [575:0] out;
   logic         out_ready;
   logic         f_ack;

   int checks = 0;
   int errors = 0;

   keccak_padder dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in),
      .in_ready    (in_ready),
      .is_last     (is_last),
      .byte_num    (byte_num),
      .buffer_full (buffer_full),
      .out         (out),
      .out_ready   (out_ready),
      .f_ack       (f_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
      in       = w;
      in_ready = 1'b1;
      is_last  = last;
      byte_num = bn;
      tick();
      in_ready = 1'b0;
      is_last  = 1'b0;
      byte_num = 2'd0;
      in       = 32'h0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!out_ready && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic ack();
      f_ack = 1'b1;
      tick();
      f_ack = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out"}, out, 576'h0);
      check({tag, "_ready"}, 576'(out_ready), 576'h0);
      check({tag, "_full"}, 576'(buffer_full), 576'h0);
   endtask

   logic [575:0] exp_empty;
   logic [575:0] exp_blk;
   int           lat;

   initial begin
      reset    = 1'b1;
      in       = 32'h0;
      in_ready = 1'b0;
      is_last  = 1'b0;
      byte_num = 2'd0;
      f_ack    = 1'b0;
      exp_empty = {32'h0600_0000, 512'h0, 32'h0000_0080};

      // ---------------- empty message ----------------
      do_reset();
      check_idle("reset");
      send(32'hFFFF_FFFF, 1'b1, 2'd0);
      check("empty_pad_full", 576'(buffer_full), 576'h1);
      check("empty_pad_ready", 576'(out_ready), 576'h0);
      wait_ready(lat);
      check("empty_latency", 576'(lat), 576'd17);
      check("empty_block", out, exp_empty);
      ack();
      check("empty_done_ready", 576'(out_ready), 576'h0);
      check("empty_done_full", 576'(buffer_full), 576'h1);
      check("empty_done_out", out, 576'h0);

      // ---------------- DONE lock ----------------
      for (int i = 0; i < 50; i++) begin
         in       = $urandom;
         in_ready = 1'($urandom_range(0, 1));
         is_last  = 1'($urandom_range(0, 1));
         byte_num = 2'($urandom_range(0, 3));
         f_ack    = 1'($urandom_range(0, 1));
         tick();
         check("done_out", out, 576'h0);
         check("done_ready", 576'(out_ready), 576'h0);
         check("done_full", 576'(buffer_full), 576'h1);
      end
      in_ready = 1'b0;
      is_last  = 1'b0;
      f_ack    = 1'b0;

      // ---------------- pad at index 17 ----------------
      do_reset();
      check_idle("reset2");
      for (int i = 0; i < 17; i++) send(32'h0101_0101, 1'b0, 2'd0);
      check("p17_not_ready", 576'(out_ready), 576'h0);
      send(32'hAABB_CCDD, 1'b1, 2'd3);
      check("p17_ready", 576'(out_ready), 576'h1);
      check("p17_low_word", 576'(out[31:0]), 576'(32'hAABB_CC86));
      check("p17_block", out, {{17{32'h0101_0101}}, 32'hAABB_CC86});
      ack();
      check("p17_done_full", 576'(buffer_full), 576'h1);
      check("p17_done_ready", 576'(out_ready), 576'h0);

      // ---------------- two blocks with back-pressure ----------------
      do_reset();
      exp_blk = '0;
      for (int i = 0; i < 18; i++) begin
         send(32'(i), 1'b0, 2'd0);
         exp_blk = {exp_blk[543:0], 32'(i)};
         if (i == 0) check("tb_first_word", 576'(out[31:0]), 576'h0);
         if (i == 1) check("tb_second_word", 576'(out[63:0]), 576'(64'h0000_0000_0000_0001));
      end
      check("tb_ready", 576'(out_ready), 576'h1);
      check("tb_block1", out, exp_blk);
      for (int i = 0; i < 5; i++) begin
         in       = 32'hDEAD_BEEF;
         in_ready = 1'b1;
         tick();
         check("bp_out", out, exp_blk);
         check("bp_ready", 576'(out_ready), 576'h1);
         check("bp_full", 576'(buffer_full), 576'h1);
      end
      in_ready = 1'b0;
      ack();
      check("tb_ack_full", 576'(buffer_full), 576'h0);
      check("tb_ack_ready", 576'(out_ready), 576'h0);
      check("tb_ack_out", out, 576'h0);
      send(32'h1122_3344, 1'b1, 2'd1);
      wait_ready(lat);
      check("tb_latency2", 576'(lat), 576'd17);
      check("tb_block2", out, {32'h1106_0000, 512'h0, 32'h0000_0080});
      ack();
      check("tb_done_full", 576'(buffer_full), 576'h1);

      // ---------------- input during PAD ----------------
      do_reset();
      send(32'hA000_0000, 1'b0, 2'd0);
      send(32'hB000_0000, 1'b0, 2'd0);
      send(32'hC1C2_C3C4, 1'b1, 2'd2);
      lat = 0;
      while (!out_ready && lat < 40) begin
         in       = 32'hFFFF_FFFF;
         in_ready = (lat % 2) == 0;
         is_last  = (lat % 3) == 0;
         byte_num = 2'd3;
         tick();
         lat++;
      end
      in_ready = 1'b0;
      is_last  = 1'b0;
      check("padin_latency", 576'(lat), 576'd15);
      check("padin_block", out,
            {32'hA000_0000, 32'hB000_0000, 32'hC1C2_0600, 448'h0, 32'h0000_0080});
      ack();
      check("padin_done_full", 576'(buffer_full), 576'h1);

      // ---------------- reset mid-operation ----------------
      do_reset();
      send(32'h1234_5678, 1'b1, 2'd2);
      tick();
      tick();
      check("rpad_in_pad", 576'(buffer_full), 576'h1);
      do_reset();
      check_idle("rpad");
      send(32'h0, 1'b1, 2'd0);
      wait_ready(lat);
      check("rpad_latency", 576'(lat), 576'd17);
      check("rpad_block", out, exp_empty);
      reset = 1'b1;
      f_ack = 1'b1;
      tick();
      reset = 1'b0;
      f_ack = 1'b0;
      check_idle("rfull");
      send(32'h0, 1'b1, 2'd0);
      wait_ready(lat);
      check("rfull_latency", 576'(lat), 576'd17);
      check("rfull_block", out, exp_empty);
      ack();
      check("rfull_done_full", 576'(buffer_full), 576'h1);
      check("rfull_done_out", out, 576'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keccak_padder.md
# keccak_padder

Message-side front end of the Keccak/SHA-3 low-throughput core and the producer end of the permutation's block handshake. It accepts the message as a stream of 32-bit words, applies SHA-3 padding (domain byte 0x06, final bit 0x80), and packs words into 576-bit rate blocks. It presents each complete block with `out`/`out_ready` and holds it until the permutation returns `f_ack`.

## Interface

Parameters: none. Rate is fixed at 576 bits (18 words).

- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  32  message word. Bytes are most-significant first: `in[31:24]` is the earliest byte.
- `in_ready`  in  1  `in` is valid this cycle.
- `is_last`  in  1  this word is the final, partial word of the message. Qualified by `in_ready`.
- `byte_num`  in  2  number of valid message bytes in the last word (0–3). Only meaningful with `is_last`.
- `buffer_full`  out  1  padder cannot accept input this cycle. A word presented with `in_ready` while this is 1 is dropped.
- `out`  out  576  rate block. The first word of the block is `out[575:544]`.
- `out_ready`  out  1  `out` holds a complete block.
- `f_ack`  in  1  the permutation consumed `out` this cycle. Only valid while `out_ready` is 1.

## Operation

- State machine: FILL, PAD, FULL, DONE. Counter `cnt` (0–17) gives the next word index. Flag `last_seen` records that the final word has been taken.
- Reset puts the block in FILL with `cnt`=0 and `last_seen`=0. `out`=0, `out_ready`=0, `buffer_full`=0.
- Word accept = `in_ready & ~buffer_full`. Every appended word shifts in as `out <= {out[543:0], w}`.
- FILL, non-last accept:
  - `w = in` and `cnt` increments.
  - If the appended word was index 17, go to FULL.
- FILL, last accept (`is_last`=1):
  - `w` = the top `byte_num` bytes of `in`, then byte 0x06, then zero bytes.
  - If the word index is 17, OR 0x80 into `w[7:0]`. For `byte_num`=3 this gives 0x86 in the low byte.
  - Set `last_seen`.
  - Go to FULL if the index was 17, otherwise go to PAD.
  - A final partial word always has room for 0x06, so padding never spills into an extra block.
- PAD: append one word per cycle.
  - The word is 0x00000000, except at index 17, where it is 0x00000080.
  - Go to FULL after index 17.
  - Input is ignored in PAD.
- FULL: `out_ready`=1 and `out` is held stable. On `f_ack`:
  - `out` is cleared to 0, `cnt` is cleared to 0, and `out_ready` drops on the next edge.
  - Next state is DONE if `last_seen` is 1, otherwise FILL.
- DONE: all inputs are ignored. Only `reset` leaves DONE.
- `buffer_full` = 1 in PAD, FULL and DONE. It is decoded from registered state only, with no input-to-output combinational path. This lets the permutation drive `f_ack` combinationally from `out_ready`.
- `f_ack` while `out_ready`=0 is ignored.
- `reset` wins over all other events, including a simultaneous `f_ack` or accept.

## Timing

- A non-last word accepted at edge t is visible in `out[31:0]` after edge t.
- 18 back-to-back non-last accepts (edges t..t+17) give `out_ready`=1 after edge t+17.
- Last word accepted at index j on edge t gives `out_ready`=1 after edge t+(17−j). Total latency is 18−j cycles, counted from the cycle in which the last word is presented.
- `f_ack` at edge t gives `out_ready`=0 and FILL (or DONE) after edge t. The earliest next accept is edge t+1.
- There is no accept on the `f_ack` edge, because `buffer_full`=1 throughout FULL.
- Throughput: at most one block per 19 cycles (18 accepts plus 1 ack), with no other bubbles.

## Test plan

- Empty message:
  - Stimulus: reset, then one word with `is_last`=1, `byte_num`=0.
  - Required: `out_ready` after 18 cycles; `out[575:544]`=0x06000000, `out[31:0]`=0x00000080, all other bits 0.
  - Then `f_ack`; DONE follows, with `buffer_full`=1 and `out_ready`=0.
- Pad at index 17:
  - Stimulus: 17 non-last words 0x01010101, then last word 0xAABBCCDD with `byte_num`=3.
  - Required: `out[31:0]`=0xAABBCC86; `out_ready`=1 the next cycle.
- Two-block message with back-pressure:
  - Stimulus: 18 words 0x00000000..0x00000011; hold `f_ack`=0 for 5 cycles while pulsing `in_ready`.
  - Required: `out` and `out_ready` stay stable, `buffer_full`=1, no words taken.
  - Then `f_ack`; next cycle `buffer_full`=0.
  - Then last word 0x11223344 with `byte_num`=1: second block has `out[575:544]`=0x11060000 and `out[31:0]`=0x00000080.
- Input during PAD:
  - Stimulus: last word at index 2; pulse `in_ready` with 0xFFFFFFFF during PAD.
  - Required: pulses are ignored; block words 3–16 are 0, word 17 is 0x80; `out_ready` 15 cycles after the accept.
- Reset mid-operation:
  - Stimulus: assert `reset` during PAD, and separately during FULL together with `f_ack`.
  - Required: next cycle `out`=0, `out_ready`=0, `buffer_full`=0, FILL; a new empty message then produces the same block as in the empty-message test.
- DONE lock:
  - Stimulus: after the final `f_ack`, drive 50 cycles of random input and `f_ack`.
  - Required: `out` stays 0, `out_ready`=0, `buffer_full`=1 until reset.
